// File: rtl/pipe_scoreboard.sv
// In-flight destination tracker beside the ID stage: detects RAW hazards against issued writes,
// generates stall and forwarding selects, and counts stall cycles.
module pipe_scoreboard #(
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned RF_WT       = 1,
  parameter int unsigned FWD_EN      = 0,
  parameter int unsigned FLUSH_SLOTS = 0,
  parameter int unsigned SEL_W       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_src1_i,
  input  logic                  id_has_src1_i,
  input  logic [REG_ADDR_W-1:0] id_src2_i,
  input  logic                  id_two_src_i,
  input  logic                  id_wb_en_i,
  input  logic [REG_ADDR_W-1:0] id_dest_i,
  input  logic                  id_mem_r_en_i,
  input  logic                  flush_i,
  input  logic                  freeze_i,
  output logic                  hazard_o,
  output logic [SEL_W-1:0]      fwd_sel1_o,
  output logic [SEL_W-1:0]      fwd_sel2_o,
  output logic [SEL_W-1:0]      inflight_o,
  output logic [31:0]           stall_cnt_o
);

  // With a write-through regfile the oldest slot is already visible to ID.
  localparam int unsigned CmpSlots = DEPTH - RF_WT;

  logic [DEPTH-1:0]      v_q, v_d;
  logic [DEPTH-1:0]      ld_q, ld_d;
  logic [REG_ADDR_W-1:0] dest_q [DEPTH];
  logic [REG_ADDR_W-1:0] dest_d [DEPTH];
  logic [31:0]           stall_q, stall_d;

  logic             hit1, hit2;
  logic [SEL_W-1:0] idx1, idx2;
  logic             hazard;
  logic [SEL_W-1:0] sel1, sel2;
  logic [SEL_W-1:0] inflight;

  // Youngest match wins: scan from slot0 upward and keep the first hit.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    idx1 = '0;
    idx2 = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (k < CmpSlots && v_q[k] && id_valid_i) begin
        if (!hit1 && id_has_src1_i && dest_q[k] == id_src1_i) begin
          hit1 = 1'b1;
          idx1 = SEL_W'(k);
        end
        if (!hit2 && id_two_src_i && dest_q[k] == id_src2_i) begin
          hit2 = 1'b1;
          idx2 = SEL_W'(k);
        end
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    sel1   = '0;
    sel2   = '0;
    if (FWD_EN == 0) begin
      hazard = hit1 | hit2;
    end else begin
      // Only a load still in EXE cannot be forwarded.
      hazard = ld_q[0] && ((hit1 && idx1 == '0) || (hit2 && idx2 == '0));
      if (!hazard) begin
        if (hit1) sel1 = idx1 + SEL_W'(1);
        if (hit2) sel2 = idx2 + SEL_W'(1);
      end
    end
  end

  always_comb begin
    v_d    = v_q;
    ld_d   = ld_q;
    dest_d = dest_q;
    if (!freeze_i) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        v_d[k]    = v_q[k-1];
        ld_d[k]   = ld_q[k-1];
        dest_d[k] = dest_q[k-1];
      end
      v_d[0]    = id_valid_i & id_wb_en_i & ~hazard & ~flush_i;
      ld_d[0]   = id_mem_r_en_i & v_d[0];
      dest_d[0] = id_dest_i;
      if (flush_i) begin
        for (int unsigned k = 1; k < DEPTH; k++) begin
          if (k <= FLUSH_SLOTS) v_d[k] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (hazard && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end

  always_comb begin
    inflight = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      inflight = inflight + SEL_W'(v_q[k]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q     <= '0;
      ld_q    <= '0;
      stall_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) dest_q[k] <= '0;
    end else begin
      v_q     <= v_d;
      ld_q    <= ld_d;
      stall_q <= stall_d;
      for (int unsigned k = 0; k < DEPTH; k++) dest_q[k] <= dest_d[k];
    end
  end

  assign hazard_o    = hazard;
  assign fwd_sel1_o  = sel1;
  assign fwd_sel2_o  = sel2;
  assign inflight_o  = inflight;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Scoreboard bench: a stall-only tracker and a forwarding tracker with one-slot flush kill,
// both driven by the same directed ID stream.
module tb_pipe_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_has_src1, id_two_src, id_wb_en, id_mem_r_en;
  logic [3:0] id_src1, id_src2, id_dest;
  logic       flush, freeze;

  logic        hz0, hz1;
  logic [1:0]  s10, s20, inf0, s11, s21, inf1;
  logic [31:0] st0, st1;

  typedef struct packed {
    logic        dut;
    logic        hz;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [1:0]  inf;
    logic [31:0] st;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    compared = 0;
  int    mismatched = 0;

  always #5 clk = ~clk;

  pipe_scoreboard #(.FWD_EN(0), .FLUSH_SLOTS(0)) dut0 (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_src1_i(id_src1),
    .id_has_src1_i(id_has_src1), .id_src2_i(id_src2), .id_two_src_i(id_two_src),
    .id_wb_en_i(id_wb_en), .id_dest_i(id_dest), .id_mem_r_en_i(id_mem_r_en),
    .flush_i(flush), .freeze_i(freeze), .hazard_o(hz0), .fwd_sel1_o(s10),
    .fwd_sel2_o(s20), .inflight_o(inf0), .stall_cnt_o(st0)
  );

  pipe_scoreboard #(.FWD_EN(1), .FLUSH_SLOTS(1)) dut1 (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_src1_i(id_src1),
    .id_has_src1_i(id_has_src1), .id_src2_i(id_src2), .id_two_src_i(id_two_src),
    .id_wb_en_i(id_wb_en), .id_dest_i(id_dest), .id_mem_r_en_i(id_mem_r_en),
    .flush_i(flush), .freeze_i(freeze), .hazard_o(hz1), .fwd_sel1_o(s11),
    .fwd_sel2_o(s21), .inflight_o(inf1), .stall_cnt_o(st1)
  );

  // Monitor: outputs are stable by the falling edge; drain everything queued this cycle.
  exp_t        e;
  string       nm;
  logic [38:0] act, want;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      nm   = name_q.pop_front();
      act  = e.dut ? {hz1, s11, s21, inf1, st1} : {hz0, s10, s20, inf0, st0};
      want = {e.hz, e.s1, e.s2, e.inf, e.st};
      compared++;
      if (act !== want) begin
        mismatched++;
        $display("FAIL %s dut%0d: got hz=%0b sel1=%0d sel2=%0d infl=%0d stall=%0d, want hz=%0b sel1=%0d sel2=%0d infl=%0d stall=%0d",
                 nm, e.dut, act[38], act[37:36], act[35:34], act[33:32], act[31:0],
                 e.hz, e.s1, e.s2, e.inf, e.st);
      end
    end
  end

  task automatic expect_out(input string n, input logic d, input logic hz, input logic [1:0] e1,
                            input logic [1:0] e2, input logic [1:0] inf, input logic [31:0] st);
    exp_t x;
    x = '{dut: d, hz: hz, s1: e1, s2: e2, inf: inf, st: st};
    exp_q.push_back(x);
    name_q.push_back(n);
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic h1, input logic [3:0] s2,
                        input logic two, input logic wb, input logic [3:0] dst, input logic ld);
    id_valid = v; id_src1 = s1; id_has_src1 = h1; id_src2 = s2;
    id_two_src = two; id_wb_en = wb; id_dest = dst; id_mem_r_en = ld;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; freeze = 1'b0;
    idle();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    expect_out("reset_d0", 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 32'd0);
    expect_out("reset_d1", 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 32'd0);
    tick();

    // Stall-only: ADD R3, then a reader of R3 waits until R3 reaches slot2.
    do_reset();
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0);
    expect_out("t1_issue", 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 32'd0);
    tick();
    set_id(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0);
    expect_out("t1_haz_slot0", 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 32'd0);
    tick();
    expect_out("t1_haz_slot1", 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 32'd1);
    tick();
    expect_out("t1_clear", 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 32'd2);
    tick();
    idle();
    expect_out("t1_after", 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 32'd2);
    tick();

    // Forwarding distance for src2: 1, 2, then regfile.
    do_reset();
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0);
    tick();
    set_id(1'b1, 4'd1, 1'b1, 4'd3, 1'b1, 1'b1, 4'd6, 1'b0);
    expect_out("t2_fwd1", 1'b1, 1'b0, 2'd0, 2'd1, 2'd1, 32'd0);
    tick();
    set_id(1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0);
    expect_out("t2_fwd2", 1'b1, 1'b0, 2'd0, 2'd2, 2'd2, 32'd0);
    tick();
    expect_out("t2_rf", 1'b1, 1'b0, 2'd0, 2'd0, 2'd2, 32'd0);
    tick();

    // Load-use: one stall, then forward from MEM.
    do_reset();
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1);
    tick();
    set_id(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0);
    expect_out("t3_ld_stall", 1'b1, 1'b1, 2'd0, 2'd0, 2'd1, 32'd0);
    tick();
    expect_out("t3_ld_fwd", 1'b1, 1'b0, 2'd2, 2'd0, 2'd1, 32'd1);
    tick();

    // Same dest twice: the younger copy wins.
    do_reset();
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0);
    tick();
    expect_out("t4_second", 1'b1, 1'b0, 2'd0, 2'd0, 2'd1, 32'd0);
    tick();
    set_id(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    expect_out("t4_youngest", 1'b1, 1'b0, 2'd1, 2'd0, 2'd2, 32'd0);
    tick();

    // Flush: ID write of R7 squashed; dut1 also kills the post-shift slot1 (R8).
    do_reset();
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0);
    tick();
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd8, 1'b0);
    tick();
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0);
    flush = 1'b1;
    expect_out("t5_pre_d0", 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 32'd0);
    expect_out("t5_pre_d1", 1'b1, 1'b0, 2'd0, 2'd0, 2'd2, 32'd0);
    tick();
    flush = 1'b0;
    set_id(1'b1, 4'd8, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    expect_out("t5_post_d0", 1'b0, 1'b1, 2'd0, 2'd0, 2'd2, 32'd0);
    expect_out("t5_post_d1", 1'b1, 1'b0, 2'd0, 2'd0, 2'd1, 32'd0);
    tick();

    // Freeze four cycles with R4 in slot0, then async reset while still frozen.
    do_reset();
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0);
    tick();
    freeze = 1'b1;
    set_id(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0);
    expect_out("t6_frz_d1", 1'b1, 1'b0, 2'd1, 2'd0, 2'd1, 32'd0);
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("t6_frz%0d", i), 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 32'(i));
      tick();
    end
    expect_out("t6_frz_end", 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 32'd4);
    tick();
    rst = 1'b0;
    expect_out("t6_rst_d0", 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 32'd0);
    expect_out("t6_rst_d1", 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    freeze = 1'b0;
    idle();
    tick();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
